// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with WAIT_CYCLES wait states, sized/extended loads, byte-lane stores.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t        state;
    logic [3:0]    cnt;
    logic          lat_write;
    logic [31:0]   lat_addr, lat_wdata;
    logic [2:0]    lat_func3;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          accept, enter_resp, f_write, ill, mis, err, we;
    logic [31:0]   f_addr, f_wdata, word, shifted, rdata, wd;
    logic [2:0]    f_func3;
    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [7:0]    b;
    logic [15:0]   h;
    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);
    always_comb begin
        accept     = (state == IDLE) && req_valid;
        enter_resp = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1);
        // With no wait states the access happens on the accept edge, before the latch holds the request.
        f_write    = (state == IDLE) ? req_write : lat_write;
        f_addr     = (state == IDLE) ? req_addr  : lat_addr;
        f_wdata    = (state == IDLE) ? req_wdata : lat_wdata;
        f_func3    = (state == IDLE) ? req_func3 : lat_func3;
        ill        = f_write ? (f_func3 > 3'd2) : (f_func3[1:0] == 2'b11 || f_func3 == 3'b110);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis        = (f_func3[1:0] == 2'd1 && f_addr[0]) || (f_func3[1:0] == 2'd2 && f_addr[1:0] != 2'b00);
        off        = f_addr[1:0];
`else
        mis        = 1'b0;
        off        = f_func3[1] ? 2'b00 : {f_addr[1], f_addr[0] & ~f_func3[0]};
`endif
        err        = ill || mis;
        idx        = f_addr[AW+1:2];
        word       = mem[idx];
        shifted    = word >> {off, 3'b000};
        b          = shifted[7:0];
        h          = shifted[15:0];
        rdata      = (f_func3[1:0] == 2'd0) ? {{24{b[7] & ~f_func3[2]}}, b} :
                     (f_func3[1:0] == 2'd1) ? {{16{h[15] & ~f_func3[2]}}, h} : word;
        be         = (f_func3[1:0] == 2'd0) ? (4'b0001 << off) :
                     (f_func3[1:0] == 2'd1) ? (4'b0011 << off) : 4'b1111;
        wd         = f_wdata << {off, 3'b000};
        we         = enter_resp && f_write && !err && !rst;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_func3 <= 3'd0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_func3 <= req_func3;
            end
            if (accept && WAIT_CYCLES != 0)
                cnt <= 4'(WAIT_CYCLES);
            else if (state == WAIT)
                cnt <= cnt - 4'd1;
            if (enter_resp) begin
                state     <= RESP;
                rsp_err   <= err;
                rsp_rdata <= (err || f_write) ? 32'd0 : rdata;
            end else if (accept)
                state <= WAIT;
            else if (state == RESP && rsp_ready)
                state <= IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (WAIT_CYCLES=2, DEPTH_WORDS=1024).
module tb_dmem_responder;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_write = 0, rsp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [2:0]  req_func3 = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    int          passed = 0, total = 0;
    logic [31:0] rd, rd0;
    logic        er, er0;
    int          lat;
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_func3(req_func3), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        @(negedge clk);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_func3 = f;
        @(negedge clk);
        req_valid = 0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        drive(w, a, d, f);
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        rst = 0;
        #1 chk("rel_req_ready", 32'(req_ready), 32'd1);
        xact(1, 32'h10, 32'hDEADBEEF, 3'b010);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_rdata", rd, 32'd0);
        xact(0, 32'h10, 32'h0, 3'b010);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_10", rd, 32'hDEADBEEF);
        xact(1, 32'h13, 32'h00000080, 3'b000);
        chk("sb_err", 32'(er), 32'd0);
        xact(0, 32'h13, 32'h0, 3'b000);
        chk("lb_13", rd, 32'hFFFFFF80);
        xact(0, 32'h13, 32'h0, 3'b100);
        chk("lbu_13", rd, 32'h00000080);
        xact(0, 32'h10, 32'h0, 3'b010);
        chk("lw_after_sb", rd, 32'h80ADBEEF);
        drive(0, 32'h10, 32'h0, 3'b001);
        rd0 = rsp_rdata; er0 = rsp_err;
        chk("stall_lh_10", rd0, 32'hFFFFBEEF);
        req_valid = 1; req_write = 1; req_addr = 32'h10; req_func3 = 3'b010; req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rdata", rsp_rdata, rd0);
            chk("stall_err", 32'(rsp_err), 32'(er0));
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 0; rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("stall_drop", 32'(rsp_valid), 32'd0);
        xact(0, 32'h10, 32'h0, 3'b010);
        chk("stall_no_write", rd, 32'h80ADBEEF);
        xact(0, 32'h11, 32'h0, 3'b001);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lh_11_err", 32'(er), 32'd1);
        chk("lh_11_data", rd, 32'd0);
`else
        chk("lh_11_err", 32'(er), 32'd0);
        chk("lh_11_data", rd, 32'hFFFFBEEF);
`endif
        xact(1, 32'h20, 32'hCAFEF00D, 3'b010);
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'h12345678; req_func3 = 3'b010;
        @(negedge clk);
        req_valid = 0;
        rst = 1;
        #1;
        chk("wrst_req_ready", 32'(req_ready), 32'd0);
        chk("wrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("wrst_rdata", rsp_rdata, 32'd0);
        chk("wrst_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 0;
        #1 chk("wrst_rel_ready", 32'(req_ready), 32'd1);
        xact(0, 32'h20, 32'h0, 3'b010);
        chk("lw_20_kept", rd, 32'hCAFEF00D);
        xact(0, 32'h10, 32'h0, 3'b011);
        chk("ill_ld_err", 32'(er), 32'd1);
        chk("ill_ld_data", rd, 32'd0);
        xact(1, 32'h10, 32'h11111111, 3'b011);
        chk("ill_st_err", 32'(er), 32'd1);
        xact(0, 32'h1010, 32'h0, 3'b010);
        chk("alias_lw", rd, 32'h80ADBEEF);
        chk("alias_err", 32'(er), 32'd0);
        xact(1, 32'h16, 32'hAAAA8001, 3'b001);
        xact(0, 32'h16, 32'h0, 3'b001);
        chk("lh_16", rd, 32'hFFFF8001);
        xact(0, 32'h16, 32'h0, 3'b101);
        chk("lhu_16", rd, 32'h00008001);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
